// File: rtl/bp_cfg_initiator.sv
// bp_cfg_initiator: host-side initiator for the config link.
// Turns simple read/write requests into uncached memory commands toward a
// bp_cfg responder. It collects in-order responses and returns read data
// through a two-entry FIFO.
//
// Optional watchdog: define BP_CFG_INITIATOR_TIMEOUT_EN to build a counter
// that sets timeout_o when a response is outstanding for timeout_cycles_p
// cycles. Without the macro, timeout_o is tied low.
//
// The processor widths are exposed as plain parameters so that this file
// stands alone.
// Message layout, MSB to LSB: msg_type[3:0] | addr | size[2:0] | payload | data.
module bp_cfg_initiator
  #(parameter int paddr_width_p       = 40
    , parameter int dword_width_p     = 64
    , parameter int cce_block_width_p = 512
    , parameter int mem_payload_width_p = 16
    , parameter int max_outstanding_p = 4
    , parameter int timeout_cycles_p  = 1024
    , localparam int cce_mem_msg_width_lp =
        4 + paddr_width_p + 3 + mem_payload_width_p + cce_block_width_p
    )
  (input  logic                            clk_i
   , input  logic                          reset_i

   , input  logic [paddr_width_p-1:0]      req_addr_i
   , input  logic [dword_width_p-1:0]      req_data_i
   , input  logic                          req_w_i
   , input  logic                          req_v_i
   , output logic                          req_ready_o

   , output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o
   , output logic                          mem_cmd_v_o
   , input  logic                          mem_cmd_ready_i

   , input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i
   , input  logic                          mem_resp_v_i
   , output logic                          mem_resp_yumi_o

   , output logic [dword_width_p-1:0]      rdata_o
   , output logic                          rdata_v_o
   , input  logic                          rdata_yumi_i

   , output logic                          idle_o
   , output logic                          err_o
   , output logic                          timeout_o
   );

  localparam logic [3:0] e_cce_mem_uc_rd = 4'b0010;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'b0011;
  localparam logic [2:0] e_mem_size_8    = 3'b011;

  localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
  localparam int occ_width_lp    = credit_width_lp + 1;
  localparam logic [occ_width_lp-1:0] max_occ_lp = occ_width_lp'(max_outstanding_p);

  typedef struct packed {
    logic [3:0]                     msg_type;
    logic [paddr_width_p-1:0]       addr;
    logic [2:0]                     size;
    logic [mem_payload_width_p-1:0] payload;
    logic [cce_block_width_p-1:0]   data;
  } mem_msg_s;

  mem_msg_s req_msg, slot_msg, resp_msg;

  logic slot_full, accept, cmd_fire;
  logic [credit_width_lp-1:0] credits;
  logic [occ_width_lp-1:0]    occupancy;
  logic no_credit, credit_return, room;

  logic resp_is_rd, resp_is_wr;
  logic fifo_ready, fifo_push, fifo_pop;
  logic [dword_width_p-1:0] fifo_mem [2];
  logic fifo_wptr, fifo_rptr;
  logic [1:0] fifo_count;

  assign resp_msg   = mem_resp_i;
  assign resp_is_rd = (resp_msg.msg_type == e_cce_mem_uc_rd);
  assign resp_is_wr = (resp_msg.msg_type == e_cce_mem_uc_wr);

  assign cmd_fire  = slot_full & mem_cmd_ready_i;
  assign no_credit = (credits == '0);

  // Three kinds of response are always consumed and dropped:
  // stray responses, unknown-type responses and write responses.
  // A read response waits until the FIFO has space.
  assign fifo_ready      = (fifo_count != 2'd2);
  assign mem_resp_yumi_o = ~reset_i & mem_resp_v_i
                           & (no_credit | ~resp_is_rd | fifo_ready);
  assign credit_return   = mem_resp_yumi_o & ~no_credit;
  assign fifo_push       = mem_resp_yumi_o & resp_is_rd & ~no_credit;

  // Occupancy counts the loaded slot as if it were already issued.
  // While the slot drains, the total therefore stays the same.
  // A response consumed in this cycle frees room at once.
  assign occupancy   = {1'b0, credits} + {{credit_width_lp{1'b0}}, slot_full};
  assign room        = (occupancy < max_occ_lp) | credit_return;
  assign req_ready_o = ~reset_i & (~slot_full | mem_cmd_ready_i) & room;
  assign accept      = req_v_i & req_ready_o;

  assign mem_cmd_o   = slot_msg;
  assign mem_cmd_v_o = slot_full;

  assign rdata_v_o = (fifo_count != 2'd0);
  assign rdata_o   = fifo_mem[fifo_rptr];
  assign fifo_pop  = rdata_v_o & rdata_yumi_i;

  assign idle_o = no_credit & ~slot_full & ~rdata_v_o;

  // Build the uncached command from the incoming request
  always_comb begin
    req_msg          = '0;
    req_msg.msg_type = req_w_i ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    req_msg.addr     = req_addr_i;
    req_msg.size     = e_mem_size_8;
    if (req_w_i)
      req_msg.data = cce_block_width_p'(req_data_i);
  end

  // One-entry command slot; a refill may land in the same cycle the slot drains
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_full <= 1'b0;
      slot_msg  <= '0;
    end else begin
      slot_full <= accept | (slot_full & ~cmd_fire);
      if (accept)
        slot_msg <= req_msg;
    end
  end

  // Outstanding-command credit counter
  always_ff @(posedge clk_i) begin
    if (reset_i)
      credits <= '0;
    else begin
      case ({cmd_fire, credit_return})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Two-entry read data FIFO; space is judged on the registered count only
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_wptr  <= 1'b0;
      fifo_rptr  <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_wptr] <= resp_msg.data[dword_width_p-1:0];
        fifo_wptr           <= ~fifo_wptr;
      end
      if (fifo_pop)
        fifo_rptr <= ~fifo_rptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flag for stray responses and unknown message types
  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_o <= 1'b0;
    else if (mem_resp_yumi_o & (no_credit | ~(resp_is_rd | resp_is_wr)))
      err_o <= 1'b1;
  end

`ifdef BP_CFG_INITIATOR_TIMEOUT_EN
  localparam int wd_width_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [wd_width_lp-1:0] wd_limit_lp = wd_width_lp'(timeout_cycles_p);

  logic [wd_width_lp-1:0] wd_count, wd_next;
  logic                   timeout_r;

  assign wd_next   = wd_count + 1'b1;
  assign timeout_o = timeout_r;

  // Watchdog counts how long a response has been awaited; timeout is sticky
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_count  <= '0;
      timeout_r <= 1'b0;
    end else if (mem_resp_yumi_o | no_credit) begin
      wd_count <= '0;
    end else if (wd_count != wd_limit_lp) begin
      wd_count <= wd_next;
      if (wd_next == wd_limit_lp)
        timeout_r <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles_lp = timeout_cycles_p;
  assign timeout_o = 1'b0;
`endif

  // Response header fields and upper data beats carry nothing we need
  logic unused_resp_fields;
  assign unused_resp_fields = ^{resp_msg.addr, resp_msg.size,
                                resp_msg.payload, resp_msg.data};

endmodule

// File: tb/tb_bp_cfg_initiator.sv
// Self-checking bench for bp_cfg_initiator: table-driven single transactions
// plus hand-written credit, backpressure, error, reset and watchdog sequences.
module tb_bp_cfg_initiator;

  localparam int PADDR   = 40;
  localparam int DWORD   = 64;
  localparam int BLOCK   = 512;
  localparam int PAYLOAD = 16;
  localparam int MAXO    = 4;
  localparam int TOUT    = 16;
  localparam int MSGW    = 4 + PADDR + 3 + PAYLOAD + BLOCK;

  localparam logic [3:0] UC_RD = 4'b0010;
  localparam logic [3:0] UC_WR = 4'b0011;
  localparam logic [2:0] SIZE8 = 3'b011;

`ifdef BP_CFG_INITIATOR_TIMEOUT_EN
  localparam bit EXP_TIMEOUT = 1'b1;
`else
  localparam bit EXP_TIMEOUT = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]         msg_type;
    logic [PADDR-1:0]   addr;
    logic [2:0]         size;
    logic [PAYLOAD-1:0] payload;
    logic [BLOCK-1:0]   data;
  } msg_s;

  typedef struct {
    logic             w;
    logic [PADDR-1:0] addr;
    logic [DWORD-1:0] wdata;
    logic [DWORD-1:0] rdata;
    logic [3:0]       exp_type;
    logic [BLOCK-1:0] exp_data;
  } vec_s;

  logic             clk = 1'b0;
  logic             reset;
  logic [PADDR-1:0] req_addr;
  logic [DWORD-1:0] req_data;
  logic             req_w, req_v, req_ready;
  logic [MSGW-1:0]  mem_cmd;
  logic             mem_cmd_v, mem_cmd_ready;
  msg_s             mem_resp;
  logic             mem_resp_v, mem_resp_yumi;
  logic [DWORD-1:0] rdata;
  logic             rdata_v, rdata_yumi;
  logic             idle, err, timeout;

  int checks = 0;
  int errors = 0;
  int cmds_seen = 0;
  msg_s             exp_cmd_q[$];
  logic [DWORD-1:0] exp_rd_q[$];

  bp_cfg_initiator #(
    .paddr_width_p(PADDR), .dword_width_p(DWORD), .cce_block_width_p(BLOCK),
    .mem_payload_width_p(PAYLOAD), .max_outstanding_p(MAXO), .timeout_cycles_p(TOUT)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_w_i(req_w),
    .req_v_i(req_v), .req_ready_o(req_ready),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
    .rdata_o(rdata), .rdata_v_o(rdata_v), .rdata_yumi_i(rdata_yumi),
    .idle_o(idle), .err_o(err), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic msg_s make_cmd(input logic w, input logic [PADDR-1:0] a,
                                    input logic [DWORD-1:0] d);
    msg_s m;
    m = '0;
    m.msg_type = w ? UC_WR : UC_RD;
    m.addr     = a;
    m.size     = SIZE8;
    if (w) m.data[DWORD-1:0] = d;
    return m;
  endfunction

  // Scoreboard: every issued command is compared with the next expected one
  always @(negedge clk) begin
    msg_s got, exp;
    if (!reset && mem_cmd_v && mem_cmd_ready) begin
      cmds_seen++;
      checks++;
      got = mem_cmd;
      if (exp_cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got type %h addr %h, required no command",
                 got.msg_type, got.addr);
      end else begin
        exp = exp_cmd_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL cmd_msg: got type %h addr %h size %h payload %h data %h; required type %h addr %h size %h payload %h data %h",
                   got.msg_type, got.addr, got.size, got.payload, got.data[127:0],
                   exp.msg_type, exp.addr, exp.size, exp.payload, exp.data[127:0]);
        end
      end
    end
  end

  // Scoreboard: every popped read word is compared with the expected one
  always @(negedge clk) begin
    logic [DWORD-1:0] e;
    if (!reset && rdata_v && rdata_yumi) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %h, required none", rdata);
      end else begin
        e = exp_rd_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h required %h", rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_v = 1'b0; mem_resp_v = 1'b0; rdata_yumi = 1'b0; mem_cmd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic send_req(input logic w, input logic [PADDR-1:0] a,
                          input logic [DWORD-1:0] d, input msg_s exp);
    bit done;
    done = 1'b0;
    req_w = w; req_addr = a; req_data = d; req_v = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_cmd_q.push_back(exp);
        done = 1'b1;
      end
      tick();
    end
    req_v = 1'b0;
    check("req_accept_bound", done, 1'b1);
  endtask

  task automatic wait_cmds(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (cmds_seen >= target) ok = 1'b1;
    end
    check("cmd_issue_bound", ok, 1'b1);
  endtask

  task automatic respond(input logic [3:0] t, input logic [DWORD-1:0] d,
                         input bit push_rd, output int waited);
    msg_s r;
    r = '0; r.msg_type = t; r.size = SIZE8; r.data = '1; r.data[DWORD-1:0] = d;
    mem_resp = r; mem_resp_v = 1'b1;
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_resp_yumi) begin
        waited = i;
        if (push_rd) exp_rd_q.push_back(d);
      end
      tick();
      if (waited >= 0) break;
    end
    mem_resp_v = 1'b0;
  endtask

  vec_s vecs[6];

  initial begin
    int   waited, base, acc;
    msg_s r;
    bit   held;

    vecs[0] = '{1'b1, 40'h00_0020_0004, 64'h1, 64'h0, UC_WR, 512'h1};
    vecs[1] = '{1'b0, 40'h00_0020_0010, 64'h1234, 64'hDEAD_BEEF, UC_RD, 512'h0};
    vecs[2] = '{1'b1, 40'h00_0020_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, UC_WR,
                512'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{1'b0, 40'h00_0020_0000, 64'hAAAA, 64'h0123_4567_89AB_CDEF, UC_RD, 512'h0};
    vecs[4] = '{1'b1, 40'hFF_FFFF_FFF8, 64'h8000_0000_0000_0000, 64'h0, UC_WR,
                512'h8000_0000_0000_0000};
    vecs[5] = '{1'b0, 40'h00_0000_0000, 64'h5, 64'h0, UC_RD, 512'h0};

    req_addr = '0; req_data = '0; req_w = 1'b0; mem_resp = '0;
    do_reset();

    @(negedge clk);
    check("rst_idle", idle, 1'b1);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_cmd_v", mem_cmd_v, 1'b0);
    check("rst_rdata_v", rdata_v, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_yumi", mem_resp_yumi, 1'b0);
    tick();

    mem_cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      base = cmds_seen;
      r = '0;
      r.msg_type = vecs[k].exp_type; r.addr = vecs[k].addr; r.size = SIZE8;
      r.data = vecs[k].exp_data;
      send_req(vecs[k].w, vecs[k].addr, vecs[k].wdata, r);
      @(negedge clk);
      check("cmd_v_latency", mem_cmd_v, 1'b1);
      wait_cmds(base + 1);
      respond(vecs[k].exp_type, vecs[k].rdata, !vecs[k].w, waited);
      check("resp_yumi_same_cycle", waited, 0);
      @(negedge clk);
      if (!vecs[k].w) begin
        check("rdata_v_after_yumi", rdata_v, 1'b1);
        check("rdata_value", rdata, vecs[k].rdata);
        tick();
        @(negedge clk);
        check("rdata_v_held", rdata_v, 1'b1);
        rdata_yumi = 1'b1;
        tick();
        rdata_yumi = 1'b0;
        @(negedge clk);
      end
      check("idle_after_txn", idle, 1'b1);
      tick();
    end
    check("no_err_in_table", err, 1'b0);

    // Credit limit: hold requests with no responses
    base = cmds_seen; acc = 0;
    req_w = 1'b1; req_addr = 40'h100; req_data = 64'd100; req_v = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_cmd_q.push_back(make_cmd(1'b1, req_addr, req_data));
        acc++;
      end
      tick();
      req_addr = 40'h100 + 40'(8 * acc);
      req_data = 64'd100 + 64'(acc);
    end
    @(negedge clk);
    check("credit_accepts", acc, MAXO);
    check("credit_cmds", cmds_seen - base, MAXO);
    check("credit_ready_low", req_ready, 1'b0);
    r = '0; r.msg_type = UC_WR; r.size = SIZE8;
    tick();
    mem_resp = r; mem_resp_v = 1'b1;
    @(negedge clk);
    check("credit_resp_yumi", mem_resp_yumi, 1'b1);
    check("credit_ready_same_cycle", req_ready, 1'b1);
    if (req_ready) exp_cmd_q.push_back(make_cmd(1'b1, req_addr, req_data));
    tick();
    mem_resp_v = 1'b0; req_v = 1'b0;
    wait_cmds(base + MAXO + 1);
    for (int i = 0; i < MAXO; i++) begin
      respond(UC_WR, 64'h0, 1'b0, waited);
      check("credit_drain_yumi", waited, 0);
    end
    @(negedge clk);
    check("credit_idle", idle, 1'b1);
    tick();

    // Read backpressure: third read response waits for FIFO space
    base = cmds_seen;
    send_req(1'b0, 40'h300, 64'h0, make_cmd(1'b0, 40'h300, 64'h0));
    send_req(1'b0, 40'h308, 64'h0, make_cmd(1'b0, 40'h308, 64'h0));
    send_req(1'b0, 40'h310, 64'h0, make_cmd(1'b0, 40'h310, 64'h0));
    wait_cmds(base + 3);
    respond(UC_RD, 64'hA1, 1'b1, waited);
    check("bp_yumi_1", waited, 0);
    respond(UC_RD, 64'hB2, 1'b1, waited);
    check("bp_yumi_2", waited, 0);
    r = '0; r.msg_type = UC_RD; r.size = SIZE8; r.data[DWORD-1:0] = 64'hC3;
    mem_resp = r; mem_resp_v = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_resp_yumi) held = 1'b0;
      tick();
    end
    check("bp_third_held", held, 1'b1);
    check("bp_head_data", rdata, 64'hA1);
    rdata_yumi = 1'b1;
    @(negedge clk);
    check("bp_held_during_pop", mem_resp_yumi, 1'b0);
    tick();
    rdata_yumi = 1'b0;
    @(negedge clk);
    check("bp_third_accepted", mem_resp_yumi, 1'b1);
    if (mem_resp_yumi) exp_rd_q.push_back(64'hC3);
    tick();
    mem_resp_v = 1'b0;
    rdata_yumi = 1'b1;
    tick(); tick();
    rdata_yumi = 1'b0;
    @(negedge clk);
    check("bp_fifo_empty", rdata_v, 1'b0);
    check("bp_idle", idle, 1'b1);
    check("bp_no_err", err, 1'b0);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    tick();

    // Unknown response type: dropped, credit returned, error raised
    base = cmds_seen;
    send_req(1'b0, 40'h400, 64'h0, make_cmd(1'b0, 40'h400, 64'h0));
    wait_cmds(base + 1);
    respond(4'h5, 64'h77, 1'b0, waited);
    check("badtype_yumi", waited, 0);
    @(negedge clk);
    check("badtype_err", err, 1'b1);
    check("badtype_idle", idle, 1'b1);
    check("badtype_no_rdata", rdata_v, 1'b0);
    tick();
    do_reset();
    @(negedge clk);
    check("err_cleared_by_reset", err, 1'b0);
    tick();

    // Stray response with no credits
    r = '0; r.msg_type = UC_RD; r.size = SIZE8;
    mem_resp = r; mem_resp_v = 1'b1;
    @(negedge clk);
    check("stray_yumi", mem_resp_yumi, 1'b1);
    tick();
    mem_resp_v = 1'b0;
    @(negedge clk);
    check("stray_err", err, 1'b1);
    check("stray_no_rdata", rdata_v, 1'b0);
    tick(); tick(); tick();
    @(negedge clk);
    check("stray_err_sticky", err, 1'b1);
    check("stray_idle", idle, 1'b1);
    tick();

    // Reset with a command parked in the slot
    do_reset();
    send_req(1'b1, 40'h500, 64'h9, make_cmd(1'b1, 40'h500, 64'h9));
    @(negedge clk);
    check("park_cmd_v", mem_cmd_v, 1'b1);
    check("park_not_idle", idle, 1'b0);
    tick();
    do_reset();
    @(negedge clk);
    check("midrst_cmd_v", mem_cmd_v, 1'b0);
    check("midrst_idle", idle, 1'b1);
    check("midrst_err", err, 1'b0);
    tick();

    // Watchdog: one read that is never answered
    mem_cmd_ready = 1'b1;
    base = cmds_seen;
    send_req(1'b0, 40'h600, 64'h0, make_cmd(1'b0, 40'h600, 64'h0));
    wait_cmds(base + 1);
    repeat (5) tick();
    @(negedge clk);
    check("timeout_not_early", timeout, 1'b0);
    repeat (30) tick();
    @(negedge clk);
    check("timeout_flag", timeout, EXP_TIMEOUT);
    check("timeout_not_idle", idle, 1'b0);
    tick();
    do_reset();
    @(negedge clk);
    check("timeout_cleared", timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
